// File: rtl/pc_reg_pkg.sv
// Shared definitions for the program-counter stage: sequencer state encoding and default width.
package pc_reg_pkg;

   localparam int unsigned PcDefaultAddrWidth = 4;

   typedef enum logic [1:0] {
      StStart  = 2'd0,
      StRun    = 2'd1,
      StBubble = 2'd2,
      StHalted = 2'd3
   } pc_state_e;

endpackage

// File: rtl/pc_reg_ret_stack.sv
// Return-address LIFO for the program counter; push/pop are ignored when full/empty.
module pc_reg_ret_stack
   import pc_reg_pkg::*;
#(
   parameter int unsigned AddrWidth = PcDefaultAddrWidth,
   parameter int unsigned Depth     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [AddrWidth-1:0] push_data_i,
   output logic [AddrWidth-1:0] top_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [AddrWidth-1:0] mem_q [Depth];
   logic [AddrWidth-1:0] mem_d [Depth];
   logic [CntW-1:0]      count_q, count_d;
   logic [PtrW-1:0]      wr_idx, top_idx;

   assign wr_idx  = count_q[PtrW-1:0];
   assign top_idx = PtrW'(count_q - CntW'(1));
   assign top_o   = mem_q[top_idx];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (push_i && !full_o) begin
         mem_d[wr_idx] = push_data_i;
         count_d       = count_q + CntW'(1);
      end else if (pop_i && !empty_o) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read below the count.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_reg.sv
// Program-counter register stage with START/RUN/BUBBLE/HALTED sequencing and wrap detection.
// Optional return-address stack enabled by defining PC_CALL_STACK_EN.
module pc_reg
   import pc_reg_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = PcDefaultAddrWidth,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
`ifdef PC_CALL_STACK_EN
   ,
   parameter int unsigned           STACK_DEPTH = 4
`endif
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  en_in,
   input  logic                  load_in,
   input  logic [ADDR_WIDTH-1:0] load_addr_in,
   input  logic                  halt_in,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [ADDR_WIDTH-1:0] pc_next_out,
   output logic                  valid_out,
   output logic                  wrap_out
`ifdef PC_CALL_STACK_EN
   ,
   input  logic                  call_in,
   input  logic                  ret_in,
   output logic                  stack_err_out
`endif
);

   pc_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  valid_q, valid_d;
   logic                  wrap_q, wrap_d;

   assign pc_out      = pc_q;
   assign pc_next_out = pc_q + ADDR_WIDTH'(1);
   assign valid_out   = valid_q;
   assign wrap_out    = wrap_q;

`ifdef PC_CALL_STACK_EN
   logic                  stk_push, stk_pop, stk_full, stk_empty;
   logic [ADDR_WIDTH-1:0] stk_top;
   logic                  err_q, err_d;

   assign stack_err_out = err_q;

   pc_reg_ret_stack #(
      .AddrWidth (ADDR_WIDTH),
      .Depth     (STACK_DEPTH)
   ) u_ret_stack (
      .clk_i       (clk_in),
      .rst_ni      (rst_n_in),
      .push_i      (stk_push),
      .pop_i       (stk_pop),
      .push_data_i (pc_next_out),
      .top_o       (stk_top),
      .full_o      (stk_full),
      .empty_o     (stk_empty)
   );
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wrap_d  = 1'b0;
`ifdef PC_CALL_STACK_EN
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      err_d    = err_q;
`endif
      unique case (state_q)
         StStart, StBubble: state_d = StRun;
         StRun: begin
`ifdef PC_CALL_STACK_EN
            if (ret_in) begin
               state_d = StBubble;
               if (stk_empty) begin
                  pc_d  = RESET_ADDR;
                  err_d = 1'b1;
               end else begin
                  pc_d    = stk_top;
                  stk_pop = 1'b1;
               end
            end else if (call_in) begin
               state_d = StBubble;
               pc_d    = load_addr_in;
               // A call into a full stack still jumps; only the return address is lost.
               if (stk_full) begin
                  err_d = 1'b1;
               end else begin
                  stk_push = 1'b1;
               end
            end else
`endif
            if (load_in) begin
               state_d = StBubble;
               pc_d    = load_addr_in;
            end else if (en_in) begin
               pc_d   = pc_next_out;
               wrap_d = &pc_q;
            end
         end
         StHalted: state_d = StHalted;
         default:  state_d = StHalted;
      endcase
      // Halt outranks every other event and freezes the PC.
      if (halt_in) begin
         state_d = StHalted;
         pc_d    = pc_q;
         wrap_d  = 1'b0;
`ifdef PC_CALL_STACK_EN
         stk_push = 1'b0;
         stk_pop  = 1'b0;
         err_d    = err_q;
`endif
      end
      valid_d = (state_d == StRun);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= StStart;
         pc_q    <= RESET_ADDR;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
`ifdef PC_CALL_STACK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
`ifdef PC_CALL_STACK_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg against a cycle-level behavioural model.
// Stack scenarios run only when PC_CALL_STACK_EN is defined.
module tb_pc_reg;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, en = 1'b0, load = 1'b0, halt = 1'b0;
   logic          call = 1'b0, ret = 1'b0;
   logic [AW-1:0] la = '0;
   logic [AW-1:0] pc_out, pc_next_out;
   logic          valid_out, wrap_out;
   logic          err_out;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [AW-1:0] m_pc = '0;
   logic          m_stall = 1'b1;
   logic          m_halted = 1'b0;
   logic          m_wrap = 1'b0;
   logic          m_err = 1'b0;
   logic          m_valid;
   logic [AW-1:0] m_stk [$];

   assign m_valid = !m_halted && !m_stall;

   always #5 clk = ~clk;

`ifdef PC_CALL_STACK_EN
   localparam bit HasStack = 1'b1;
   pc_reg #(.ADDR_WIDTH(AW), .RESET_ADDR('0), .STACK_DEPTH(DEPTH)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .en_in         (en),
      .load_in       (load),
      .load_addr_in  (la),
      .halt_in       (halt),
      .pc_out        (pc_out),
      .pc_next_out   (pc_next_out),
      .valid_out     (valid_out),
      .wrap_out      (wrap_out),
      .call_in       (call),
      .ret_in        (ret),
      .stack_err_out (err_out)
   );
`else
   localparam bit HasStack = 1'b0;
   assign err_out = 1'b0;
   pc_reg #(.ADDR_WIDTH(AW), .RESET_ADDR('0)) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .en_in        (en),
      .load_in      (load),
      .load_addr_in (la),
      .halt_in      (halt),
      .pc_out       (pc_out),
      .pc_next_out  (pc_next_out),
      .valid_out    (valid_out),
      .wrap_out     (wrap_out)
   );
`endif

   // One clock of the specification's rules, applied to the model.
   task automatic model_step(input bit r, e, l, input logic [AW-1:0] a, input bit h, c, t);
      if (!r) begin
         m_pc = '0; m_stall = 1'b1; m_halted = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
         m_stk.delete();
      end else begin
         m_wrap = 1'b0;
         if (m_halted) begin
         end else if (h) begin
            m_halted = 1'b1;
         end else if (m_stall) begin
            m_stall = 1'b0;
         end else if (t) begin
            if (m_stk.size() == 0) begin
               m_pc = '0; m_err = 1'b1;
            end else begin
               m_pc = m_stk.pop_back();
            end
            m_stall = 1'b1;
         end else if (c) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else m_stk.push_back(AW'((int'(m_pc) + 1) % (1 << AW)));
            m_pc = a; m_stall = 1'b1;
         end else if (l) begin
            m_pc = a; m_stall = 1'b1;
         end else if (e) begin
            m_pc   = AW'((int'(m_pc) + 1) % (1 << AW));
            m_wrap = (m_pc == 0);
         end
      end
   endtask

   task automatic tick(input bit r, e, l, input logic [AW-1:0] a, input bit h, c, t);
      rst_n = r; en = e; load = l; la = a; halt = h;
      call = HasStack ? c : 1'b0;
      ret  = HasStack ? t : 1'b0;
      @(posedge clk);
      model_step(r, e, l, a, h, call, ret);
      #1;
   endtask

   task automatic go_to(input logic [AW-1:0] target);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < int'(target); i++) tick(1, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      tick(0, 1, 1, 4'd6, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 4'd0 || valid_out !== 1'b0 || wrap_out !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: pc=%0d valid=%0b wrap=%0b, expected pc=0 valid=0 wrap=0",
                  pc_out, valid_out, wrap_out);
      end
      n_cmp++;
      if (err_out !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_err: err=%0b, expected 0", err_out);
      end
   endtask

   task automatic test_count_wrap;
      tick(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) begin
         tick(1, 1, 0, 0, 0, 0, 0);
         n_cmp++;
         if (pc_out !== m_pc || valid_out !== m_valid || wrap_out !== m_wrap ||
             pc_next_out !== AW'(m_pc + 1)) begin
            n_bad++;
            $display("FAIL count[%0d]: pc=%0d valid=%0b wrap=%0b next=%0d, expected %0d %0b %0b %0d",
                     i, pc_out, valid_out, wrap_out, pc_next_out, m_pc, m_valid, m_wrap,
                     AW'(m_pc + 1));
         end
      end
      // 1 START cycle + 16 increments puts the wrapped zero on the 17th en cycle.
      n_cmp++;
      if (m_pc !== 4'd2 || pc_out !== 4'd2) begin
         n_bad++;
         $display("FAIL count_end: pc=%0d, expected 2", pc_out);
      end
   endtask

   task automatic test_load_bubble;
      go_to(4'd3);
      tick(1, 1, 1, 4'd9, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 4'd9 || valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL load: pc=%0d valid=%0b, expected pc=9 valid=0", pc_out, valid_out);
      end
      tick(1, 1, 1, 4'd5, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 4'd9 || valid_out !== 1'b1) begin
         n_bad++;
         $display("FAIL bubble_ignore: pc=%0d valid=%0b, expected pc=9 valid=1", pc_out, valid_out);
      end
      tick(1, 1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 4'd10 || valid_out !== 1'b1 || wrap_out !== 1'b0) begin
         n_bad++;
         $display("FAIL load_en: pc=%0d valid=%0b wrap=%0b, expected 10 1 0",
                  pc_out, valid_out, wrap_out);
      end
      tick(1, 0, 1, 4'd0, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 4'd0 || wrap_out !== 1'b0) begin
         n_bad++;
         $display("FAIL load_zero: pc=%0d wrap=%0b, expected pc=0 wrap=0", pc_out, wrap_out);
      end
   endtask

   task automatic test_halt;
      go_to(4'd5);
      tick(1, 1, 1, 4'd12, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (pc_out !== 4'd5 || valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL halt[%0d]: pc=%0d valid=%0b, expected pc=5 valid=0", i, pc_out, valid_out);
         end
         tick(1, 1, i[0], 4'd1, 0, 1, 0);
      end
      tick(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 4'd0 || valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_reset: pc=%0d valid=%0b, expected pc=0 valid=0", pc_out, valid_out);
      end
   endtask

`ifdef PC_CALL_STACK_EN
   task automatic test_call_ret;
      go_to(4'd2);
      tick(1, 0, 0, 4'd8, 0, 1, 0);
      n_cmp++;
      if (pc_out !== 4'd8 || valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL call: pc=%0d valid=%0b, expected pc=8 valid=0", pc_out, valid_out);
      end
      tick(1, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (pc_out !== 4'd3 || err_out !== 1'b0) begin
         n_bad++;
         $display("FAIL ret: pc=%0d err=%0b, expected pc=3 err=0", pc_out, err_out);
      end
      tick(1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         tick(1, 0, 0, AW'(i), 0, 1, 0);
         tick(1, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if (pc_out !== AW'(i) || err_out !== (i == 5)) begin
            n_bad++;
            $display("FAIL nest[%0d]: pc=%0d err=%0b, expected pc=%0d err=%0b",
                     i, pc_out, err_out, i, (i == 5));
         end
      end
   endtask

   task automatic test_underflow;
      go_to(4'd7);
      tick(1, 1, 1, 4'd9, 0, 1, 1);
      n_cmp++;
      if (pc_out !== 4'd0 || err_out !== 1'b1) begin
         n_bad++;
         $display("FAIL underflow: pc=%0d err=%0b, expected pc=0 err=1", pc_out, err_out);
      end
      for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (err_out !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: err=%0b, expected 1", err_out);
      end
      tick(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (err_out !== 1'b0) begin
         n_bad++;
         $display("FAIL err_reset: err=%0b, expected 0", err_out);
      end
   endtask
`endif

   task automatic test_random;
      tick(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         tick($urandom_range(0, 99) >= 3, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
              AW'($urandom), $urandom_range(0, 99) < 2, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0);
         n_cmp++;
         if (pc_out !== m_pc || valid_out !== m_valid || wrap_out !== m_wrap ||
             pc_next_out !== AW'(m_pc + 1) || err_out !== (HasStack ? m_err : 1'b0)) begin
            n_bad++;
            $display("FAIL random[%0d]: pc=%0d valid=%0b wrap=%0b err=%0b, expected %0d %0b %0b %0b",
                     i, pc_out, valid_out, wrap_out, err_out, m_pc, m_valid, m_wrap, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_wrap();
      test_load_bubble();
      test_halt();
`ifdef PC_CALL_STACK_EN
      test_call_ret();
      test_underflow();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
